exp6_mostra_sequencia: RTL and testbench

EXP6_MOSTRA_SEQUENCIA -- requirements
Module: exp6_mostra_sequencia

---
 rtl/exp6_mostra_sequencia_pkg.sv | 30 +++
 rtl/contador_timer.sv | 39 +++
 rtl/exp6_mostra_sequencia.sv | 146 ++++++++++++++
 tb/tb_exp6_mostra_sequencia.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/exp6_mostra_sequencia_pkg.sv
// Shared definitions for the sequence display block and the game control unit:
// state encodings, default phase durations and the phase-timer sizing helper.
package exp6_mostra_sequencia_pkg;

    // Default number of cycles an element stays lit, and dark cycles after it.
    localparam int unsigned T_ON_PADRAO  = 4;
    localparam int unsigned T_OFF_PADRAO = 2;

    // Debug code reported when the state register holds an unused encoding.
    localparam logic [3:0] DB_INVALIDO = 4'hF;

    // Sequence display states; the encodings are visible on db_estado.
    typedef enum logic [3:0] {
        StOcioso  = 4'd0,
        StPrepara = 4'd1,
        StAcende  = 4'd2,
        StApaga   = 4'd3,
        StAvanca  = 4'd4,
        StFim     = 4'd5
    } estado_t;

    // Timer width: enough bits to count 0..max(t_on,t_off)-1, at least one bit.
    function automatic int unsigned largura_timer(input int unsigned t_on,
                                                  input int unsigned t_off);
        int unsigned maior;
        maior = (t_on > t_off) ? t_on : t_off;
        return (maior > 1) ? $clog2(maior) : 1;
    endfunction

endpackage

// File: rtl/contador_timer.sv
// Phase timer: modulo counter whose terminal value is chosen by the caller.
// o_fim flags the terminal count; counting past it returns to zero, so a phase
// ends with the counter already cleared for the next phase.
module contador_timer #(
    parameter int unsigned W = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         i_zera,
    input  logic         i_conta,
    input  logic [W-1:0] i_ultimo,
    output logic         o_fim
);

    logic [W-1:0] r_valor;
    logic [W-1:0] w_valor_prox;

    assign o_fim = (r_valor == i_ultimo);

    // Next count: clear has priority, then wrap at the terminal value.
    always_comb begin
        w_valor_prox = r_valor;
        if (i_zera) begin
            w_valor_prox = '0;
        end else if (i_conta) begin
            w_valor_prox = o_fim ? '0 : (r_valor + 1'b1);
        end
    end

    // Count register with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_valor <= '0;
        end else begin
            r_valor <= w_valor_prox;
        end
    end

endmodule

// File: rtl/exp6_mostra_sequencia.sv
// Sequence display: shows memory entries 0..limite one at a time on leds,
// each lit for T_ON cycles followed by T_OFF dark cycles, then pulses pronto.
module exp6_mostra_sequencia
    import exp6_mostra_sequencia_pkg::*;
#(
    parameter int unsigned T_ON  = T_ON_PADRAO,
    parameter int unsigned T_OFF = T_OFF_PADRAO
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       cancelar,
    input  logic [3:0] limite,
    input  logic [3:0] dado_mem,
    output logic [3:0] endereco,
    output logic [3:0] leds,
    output logic       mostrando,
    output logic       pronto,
    output logic [3:0] db_estado
);

    localparam int unsigned   TW      = largura_timer(T_ON, T_OFF);
    localparam logic [TW-1:0] ULT_ON  = TW'(T_ON - 1);
    localparam logic [TW-1:0] ULT_OFF = TW'(T_OFF - 1);

    estado_t       r_estado;
    estado_t       w_estado_prox;
    logic [3:0]    r_endereco;
    logic [3:0]    r_limite;
    logic          w_timer_zera;
    logic          w_timer_conta;
    logic          w_timer_fim;
    logic [TW-1:0] w_timer_ultimo;

    // Terminal count depends on which phase is being timed.
    assign w_timer_ultimo = (r_estado == StApaga) ? ULT_OFF : ULT_ON;

    contador_timer #(
        .W (TW)
    ) u_timer (
        .clock    (clock),
        .reset    (reset),
        .i_zera   (w_timer_zera),
        .i_conta  (w_timer_conta),
        .i_ultimo (w_timer_ultimo),
        .o_fim    (w_timer_fim)
    );

    // Next-state and timer control; cancelar overrides every transition.
    always_comb begin
        w_estado_prox = r_estado;
        w_timer_zera  = 1'b1;
        w_timer_conta = 1'b0;
        case (r_estado)
            StOcioso: begin
                if (iniciar) begin
                    w_estado_prox = StPrepara;
                end
            end
            StPrepara: begin
                w_estado_prox = StAcende;
            end
            StAcende: begin
                w_timer_zera  = 1'b0;
                w_timer_conta = 1'b1;
                if (w_timer_fim) begin
                    w_estado_prox = StApaga;
                end
            end
            StApaga: begin
                w_timer_zera  = 1'b0;
                w_timer_conta = 1'b1;
                if (w_timer_fim) begin
                    w_estado_prox = (r_endereco == r_limite) ? StFim : StAvanca;
                end
            end
            StAvanca: begin
                w_estado_prox = StAcende;
            end
            StFim: begin
                w_estado_prox = StOcioso;
            end
            default: begin
                w_estado_prox = StOcioso;
            end
        endcase
        if (cancelar) begin
            w_estado_prox = StOcioso;
            w_timer_zera  = 1'b1;
            w_timer_conta = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado <= StOcioso;
        end else begin
            r_estado <= w_estado_prox;
        end
    end

    // Address counter and latched limit; an abort freezes both where they are.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_endereco <= '0;
            r_limite   <= '0;
        end else if (!cancelar) begin
            if (r_estado == StPrepara) begin
                r_endereco <= '0;
                r_limite   <= limite;
            end else if (r_estado == StAvanca) begin
                r_endereco <= r_endereco + 1'b1;
            end
        end
    end

    assign endereco = r_endereco;

    // Moore outputs from the state; only ACENDE forwards memory data to leds.
    always_comb begin
        leds      = '0;
        mostrando = 1'b0;
        pronto    = 1'b0;
        db_estado = r_estado;
        case (r_estado)
            StOcioso: begin
                mostrando = 1'b0;
            end
            StPrepara, StApaga, StAvanca: begin
                mostrando = 1'b1;
            end
            StAcende: begin
                mostrando = 1'b1;
                leds      = dado_mem;
            end
            StFim: begin
                pronto = 1'b1;
            end
            default: begin
                db_estado = DB_INVALIDO;
            end
        endcase
    end

endmodule

// File: tb/tb_exp6_mostra_sequencia.sv
// Self-checking bench for exp6_mostra_sequencia: table of sequence runs checked
// cycle by cycle against a schedule-based reference, plus reset corner cases.
module tb_exp6_mostra_sequencia;

    localparam int T_ON  = 4;
    localparam int T_OFF = 2;
    localparam int P     = T_ON + T_OFF + 1;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       iniciar = 1'b0;
    logic       cancelar = 1'b0;
    logic [3:0] limite = 4'd0;
    logic [3:0] dado_mem;
    logic [3:0] endereco;
    logic [3:0] leds;
    logic       mostrando;
    logic       pronto;
    logic [3:0] db_estado;

    logic [3:0] mem [16];

    typedef struct packed {
        logic [3:0] leds;
        logic [3:0] endereco;
        logic       mostrando;
        logic       pronto;
        logic [3:0] db;
    } saida_t;

    typedef struct {
        int limite;
        int semente;
        bit perturba;
        int cancela_em;
    } vetor_t;

    saida_t fila [$];
    int     checks  = 0;
    int     errors  = 0;
    int     end_ant = 0;

    exp6_mostra_sequencia #(
        .T_ON  (T_ON),
        .T_OFF (T_OFF)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .iniciar   (iniciar),
        .cancelar  (cancelar),
        .limite    (limite),
        .dado_mem  (dado_mem),
        .endereco  (endereco),
        .leds      (leds),
        .mostrando (mostrando),
        .pronto    (pronto),
        .db_estado (db_estado)
    );

    always #5 clock = ~clock;

    assign dado_mem = mem[endereco];

    task automatic cmp(input string nome, input logic [31:0] obtido, input logic [31:0] esperado);
        checks++;
        if (obtido !== esperado) begin
            errors++;
            $display("FAIL %s: obtido %0h esperado %0h", nome, obtido, esperado);
        end
    endtask

    // Expected outputs in cycle c after the edge that sampled iniciar, from the
    // published schedule: PREPARA, then per element T_ON lit, T_OFF dark, one step.
    function automatic saida_t modelo(input int c, input int lim, input int ea);
        saida_t s;
        int p, k, r;
        s = '0;
        if (c == 1) begin
            s.endereco  = 4'(ea);
            s.mostrando = 1'b1;
            s.db        = 4'd1;
            return s;
        end
        p = c - 2;
        k = p / P;
        r = p % P;
        if (k > lim) begin
            s.endereco = 4'(lim);
            return s;
        end
        s.endereco = 4'(k);
        if (r < T_ON) begin
            s.leds      = mem[k];
            s.mostrando = 1'b1;
            s.db        = 4'd2;
        end else if (r < T_ON + T_OFF) begin
            s.mostrando = 1'b1;
            s.db        = 4'd3;
        end else if (k == lim) begin
            s.pronto = 1'b1;
            s.db     = 4'd5;
        end else begin
            s.mostrando = 1'b1;
            s.db        = 4'd4;
        end
        return s;
    endfunction

    task automatic comparar(input int c);
        saida_t e;
        saida_t a;
        a = {leds, endereco, mostrando, pronto, db_estado};
        if (fila.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL fila vazia ciclo %0d: obtido %0h esperado nada", c, a);
        end else begin
            e = fila.pop_front();
            cmp($sformatf("ciclo %0d {leds,end,most,pronto,db}", c), 32'(a), 32'(e));
        end
    endtask

    task automatic carregar_mem(input int semente);
        for (int i = 0; i < 16; i++) begin
            mem[i] = 4'(1 << ((i + semente) % 4));
        end
    endtask

    task automatic rodar(input vetor_t v);
        int     ncic;
        saida_t e;
        saida_t ec;
        carregar_mem(v.semente);
        ec      = '0;
        e       = '0;
        limite  = 4'(v.limite);
        iniciar = 1'b1;
        @(posedge clock);
        #1 iniciar = 1'b0;
        ncic = v.limite * P + 9;
        for (int c = 1; c <= ncic; c++) begin
            if (v.cancela_em > 0 && c > v.cancela_em) begin
                e          = '0;
                e.endereco = ec.endereco;
            end else begin
                e = modelo(c, v.limite, end_ant);
            end
            if (c == v.cancela_em) ec = e;
            fila.push_back(e);
            @(negedge clock);
            comparar(c);
            @(posedge clock);
            #1;
            iniciar  = 1'b0;
            cancelar = 1'b0;
            if (v.perturba && c + 1 == 3) iniciar = 1'b1;
            if (v.perturba && c + 1 == 7) limite = 4'd7;
            if (c + 1 == v.cancela_em) cancelar = 1'b1;
        end
        end_ant = int'(e.endereco);
    endtask

    vetor_t tabela [6];

    initial begin
        tabela[0] = '{limite: 2,  semente: 0, perturba: 1'b0, cancela_em: 0};
        tabela[1] = '{limite: 0,  semente: 3, perturba: 1'b0, cancela_em: 0};
        tabela[2] = '{limite: 15, semente: 1, perturba: 1'b0, cancela_em: 0};
        tabela[3] = '{limite: 2,  semente: 0, perturba: 1'b1, cancela_em: 0};
        tabela[4] = '{limite: 2,  semente: 2, perturba: 1'b0, cancela_em: 13};
        tabela[5] = '{limite: 5,  semente: 1, perturba: 1'b0, cancela_em: 0};

        carregar_mem(0);
        #12;
        cmp("reset leds", 32'(leds), 32'h0);
        cmp("reset db_estado", 32'(db_estado), 32'h0);
        cmp("reset endereco", 32'(endereco), 32'h0);
        cmp("reset mostrando/pronto", 32'({mostrando, pronto}), 32'h0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;

        for (int t = 0; t < 6; t++) begin
            rodar(tabela[t]);
        end

        // Reset in the middle of ACENDE: outputs clear at once, no pronto later.
        carregar_mem(0);
        limite  = 4'd2;
        iniciar = 1'b1;
        @(posedge clock);
        #1 iniciar = 1'b0;
        repeat (2) begin
            @(posedge clock);
            #1;
        end
        @(negedge clock);
        cmp("leds antes do reset", 32'(leds), 32'h1);
        #2 reset = 1'b0;
        #1;
        cmp("reset assinc leds", 32'(leds), 32'h0);
        cmp("reset assinc db_estado", 32'(db_estado), 32'h0);
        cmp("reset assinc endereco", 32'(endereco), 32'h0);
        cmp("reset assinc mostrando/pronto", 32'({mostrando, pronto}), 32'h0);
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            cmp($sformatf("pos-reset ocioso %0d {pronto,db}", i), 32'({pronto, db_estado}),
                32'h0);
        end
        end_ant = 0;
        @(posedge clock);
        #1;
        rodar('{limite: 0, semente: 3, perturba: 1'b0, cancela_em: 0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
